// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ifq_pkg;

   typedef enum logic [2:0] {
      ST_RST        = 3'd0,
      ST_FETCH_REQ  = 3'd1,
      ST_STALL      = 3'd2,
      ST_FETCH_WAIT = 3'd3,
      ST_FLUSH      = 3'd4,
      ST_DRAIN      = 3'd5
   } ifq_state_t;

   // Bytes covered by one cache line of 32-bit words.
   function automatic int line_bytes(input int words_per_line);
      return 4 * words_per_line;
   endfunction

   // Width of a word offset inside a line (OFFSET_W).
   function automatic int offset_w(input int words_per_line);
      return $clog2(words_per_line);
   endfunction

   // A line may only be requested when the FIFO can absorb every word of it.
   function automatic logic credit_ok(input int count, input int depth, input int words_per_line);
      return (count <= (depth - words_per_line));
   endfunction

endpackage

// File: rtl/ifq_line_counter.sv
// Per-line bookkeeping: returning-word index, words to skip after a redirect, words left to drain.
// Latency: all values update one cycle after their control strobe.
// Backpressure: none; the controller decides when each strobe fires.
module ifq_line_counter
   import ifq_pkg::*;
#(
   parameter int WORDS_PER_LINE = 4,
   parameter int OFFSET_W       = offset_w(WORDS_PER_LINE),
   parameter int CNT_W          = $clog2(WORDS_PER_LINE + 1)
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                inc_i,
   input  logic                clear_i,
   input  logic                load_i,
   input  logic [OFFSET_W-1:0] skip_val_i,
   input  logic                drain_ld_i,
   input  logic [CNT_W-1:0]    drain_val_i,
   input  logic                drain_dec_i,
   output logic [OFFSET_W-1:0] word_idx_o,
   output logic [OFFSET_W-1:0] skip_o,
   output logic [CNT_W-1:0]    drain_o
);

   logic [OFFSET_W-1:0] word_idx_q, word_idx_d;
   logic [OFFSET_W-1:0] skip_q, skip_d;
   logic [CNT_W-1:0]    drain_q, drain_d;

   // Next-state: a redirect restarts the line (index 0, new skip); drain is loaded or counted down separately.
   always_comb begin
      word_idx_d = word_idx_q;
      skip_d     = skip_q;
      drain_d    = drain_q;
      if (load_i) begin
         word_idx_d = '0;
         skip_d     = skip_val_i;
      end else begin
         if (inc_i) begin
            word_idx_d = (word_idx_q == OFFSET_W'(WORDS_PER_LINE - 1)) ? '0 : word_idx_q + OFFSET_W'(1);
         end
         if (clear_i) begin
            skip_d = '0;
         end
      end
      if (drain_ld_i) begin
         drain_d = drain_val_i;
      end else if (drain_dec_i && (drain_q != '0)) begin
         drain_d = drain_q - CNT_W'(1);
      end
   end

   // Counter registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         word_idx_q <= '0;
         skip_q     <= '0;
         drain_q    <= '0;
      end else begin
         word_idx_q <= word_idx_d;
         skip_q     <= skip_d;
         drain_q    <= drain_d;
      end
   end

   assign word_idx_o = word_idx_q;
   assign skip_o     = skip_q;
   assign drain_o    = drain_q;

endmodule

// File: rtl/ifq_fetch_ctrl.sv
// Sequences I-cache line fetches into the instruction FIFO, with redirect, skip, drain and decode bypass.
// Latency: cache word to bypass/push is 0 cycles; cache_req one cycle after entering FETCH_REQ.
// Backpressure: a line is requested only when the FIFO has room for all its words, otherwise STALL.
module ifq_fetch_ctrl
   import ifq_pkg::*;
#(
   parameter int              WORDS_PER_LINE = 4,
   parameter int              FIFO_DEPTH     = 16,
   parameter int              PC_W           = 32,
   parameter logic [PC_W-1:0] RESET_PC       = '0
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               dout_valid,
   input  logic                               rd_enable,
   input  logic                               branch_valid,
   input  logic [PC_W-1:0]                    branch_target,
   input  logic                               fifo_empty,
   input  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
   input  logic                               fifo_full,
   output logic                               flush,
   output logic                               cache_req,
   output logic [PC_W-1:0]                    pc_out,
   output logic                               bypass,
   output logic                               push_fifo,
   output logic                               pop_fifo,
   output logic [$clog2(WORDS_PER_LINE)-1:0]  word_idx
);

   localparam int OFFSET_W     = offset_w(WORDS_PER_LINE);
   localparam int CNT_W        = $clog2(WORDS_PER_LINE + 1);
   localparam int LINE_BYTES_C = line_bytes(WORDS_PER_LINE);
   localparam int LB_W         = $clog2(LINE_BYTES_C);
   localparam logic [PC_W-1:0] LINE_MASK = ~PC_W'(LINE_BYTES_C - 1);

   ifq_state_t          state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic                flush_q;

   logic [OFFSET_W-1:0] word_idx_q;
   logic [OFFSET_W-1:0] skip_q;
   logic [CNT_W-1:0]    drain_q;
   logic [CNT_W-1:0]    drain_left;
   logic [CNT_W-1:0]    drain_val;

   logic                credit;
   logic                branch_act;
   logic                in_drain;
   logic                drain_dec;
   logic                last_word;
   logic                accept_word;

   assign credit      = credit_ok(int'(fifo_count), FIFO_DEPTH, WORDS_PER_LINE);
   assign branch_act  = branch_valid && (state_q != ST_RST);
   assign in_drain    = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
   assign drain_dec   = in_drain && dout_valid && (drain_q != '0);
   assign drain_left  = drain_q - CNT_W'(drain_dec);
   assign last_word   = (state_q == ST_FETCH_WAIT) && dout_valid &&
                        (word_idx_q == OFFSET_W'(WORDS_PER_LINE - 1));
   assign accept_word = (state_q == ST_FETCH_WAIT) && dout_valid && (word_idx_q >= skip_q);

   // Words of the current line still in flight, not counting one arriving in this same cycle.
   assign drain_val   = (state_q == ST_FETCH_WAIT) ?
                        CNT_W'(WORDS_PER_LINE) - CNT_W'(word_idx_q) - CNT_W'(dout_valid) : '0;

   ifq_line_counter #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .OFFSET_W       (OFFSET_W),
      .CNT_W          (CNT_W)
   ) u_line_counter (
      .clk_i       (clk),
      .rst_n_i     (reset),
      .inc_i       ((state_q == ST_FETCH_WAIT) && dout_valid && !branch_act),
      .clear_i     (last_word && !branch_act),
      .load_i      (branch_act),
      .skip_val_i  (branch_target[LB_W-1:2]),
      .drain_ld_i  (branch_act && !in_drain),
      .drain_val_i (drain_val),
      .drain_dec_i (drain_dec),
      .word_idx_o  (word_idx_q),
      .skip_o      (skip_q),
      .drain_o     (drain_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RST;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode; a redirect outranks every other transition.
   always_comb begin
      state_d = state_q;
      if (branch_act) begin
         state_d = ST_FLUSH;
      end else begin
         unique case (state_q)
            ST_RST:        state_d = ST_FETCH_REQ;
            ST_FETCH_REQ:  state_d = credit ? ST_FETCH_WAIT : ST_STALL;
            ST_STALL:      state_d = credit ? ST_FETCH_REQ : ST_STALL;
            ST_FETCH_WAIT: state_d = last_word ? ST_FETCH_REQ : ST_FETCH_WAIT;
            ST_FLUSH:      state_d = (drain_left != '0) ? ST_DRAIN : ST_FETCH_REQ;
            ST_DRAIN:      state_d = (drain_left == '0) ? ST_FETCH_REQ : ST_DRAIN;
            default:       state_d = ST_RST;
         endcase
      end
   end

   // Output decode; a redirect cycle never requests, pushes or bypasses.
   always_comb begin
      cache_req = 1'b0;
      bypass    = 1'b0;
      push_fifo = 1'b0;
      pop_fifo  = 1'b0;
      if ((state_q != ST_RST) && (state_q != ST_FLUSH)) begin
         pop_fifo = rd_enable && !fifo_empty;
      end
      if (!branch_act) begin
         if (state_q == ST_FETCH_REQ) begin
            cache_req = credit;
         end
         if (accept_word) begin
            if (rd_enable && fifo_empty) begin
               bypass = 1'b1;
            end else begin
               push_fifo = 1'b1;
            end
         end
      end
   end

   // Fetch address: line-aligned redirect target, or next line after the last word returns.
   always_comb begin
      pc_d = pc_q;
      if (branch_act) begin
         pc_d = branch_target & LINE_MASK;
      end else if (last_word) begin
         pc_d = pc_q + PC_W'(LINE_BYTES_C);
      end
   end

   // Address and flush registers; flush is high for the cycle spent in FLUSH.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q    <= RESET_PC;
         flush_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         flush_q <= (state_d == ST_FLUSH);
      end
   end

   assign pc_out   = pc_q;
   assign flush    = flush_q;
   assign word_idx = word_idx_q;

   // A push into a full FIFO would lose an instruction word.
   assert property (@(posedge clk) disable iff (!reset) !(push_fifo && fifo_full));

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Bench for ifq_fetch_ctrl: directed scenarios with literal expectations, then random traffic.
// Latency: outputs compared mid-cycle against a cycle-level behavioural model.
// Backpressure: fifo_count driven directly to exercise the credit stall.
module tb_ifq_fetch_ctrl;

   localparam int          WPL   = 4;
   localparam int          DEPTH = 16;
   localparam int          LB    = 4 * WPL;
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [31:0] RST_PC = 32'h0;

   localparam int PH_RST   = 0;
   localparam int PH_REQ   = 1;
   localparam int PH_STALL = 2;
   localparam int PH_RECV  = 3;
   localparam int PH_FLUSH = 4;
   localparam int PH_DRAIN = 5;

   logic          clk = 1'b0;
   logic          reset, dout_valid, rd_enable, branch_valid, fifo_empty, fifo_full;
   logic [31:0]   branch_target;
   logic [CW-1:0] fifo_count;
   logic          flush, cache_req, bypass, push_fifo, pop_fifo;
   logic [31:0]   pc_out;
   logic [1:0]    word_idx;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifq_fetch_ctrl #(
      .WORDS_PER_LINE (WPL),
      .FIFO_DEPTH     (DEPTH),
      .PC_W           (32),
      .RESET_PC       (RST_PC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .dout_valid    (dout_valid),
      .rd_enable     (rd_enable),
      .branch_valid  (branch_valid),
      .branch_target (branch_target),
      .fifo_empty    (fifo_empty),
      .fifo_count    (fifo_count),
      .fifo_full     (fifo_full),
      .flush         (flush),
      .cache_req     (cache_req),
      .pc_out        (pc_out),
      .bypass        (bypass),
      .push_fifo     (push_fifo),
      .pop_fifo      (pop_fifo),
      .word_idx      (word_idx)
   );

   task automatic chk_b(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: which phase of a line fetch we are in, how many words of the line have
   // arrived, how many leading words to throw away, and how many stale words must still drain.
   int          ph      = PH_RST;
   int          got     = 0;
   int          skip_w  = 0;
   int          drain_n = 0;
   logic [31:0] m_pc    = RST_PC;
   bit          known   = 1'b0;

   always @(negedge clk) begin : model
      logic credit, live, br, acc;
      credit = (int'(fifo_count) + WPL <= DEPTH);
      live   = (ph != PH_RST);
      br     = branch_valid && live;
      acc    = (ph == PH_RECV) && dout_valid && (got >= skip_w) && !br;
      if (known) begin
         chk_b("m_cache_req", cache_req, (ph == PH_REQ) && credit && !br);
         chk_b("m_bypass",    bypass,    acc && rd_enable && fifo_empty);
         chk_b("m_push",      push_fifo, acc && !(rd_enable && fifo_empty));
         chk_b("m_pop",       pop_fifo,  live && (ph != PH_FLUSH) && rd_enable && !fifo_empty);
         chk_b("m_flush",     flush,     ph == PH_FLUSH);
         chk_w("m_pc",        pc_out,    m_pc);
         chk_w("m_word_idx",  32'(word_idx), got);
      end
      if (!reset) begin
         known = 1'b1; ph = PH_RST; got = 0; skip_w = 0; drain_n = 0; m_pc = RST_PC;
      end else if (known) begin
         if (br) begin
            if (ph == PH_RECV) drain_n = WPL - got - int'(dout_valid);
            else if (ph == PH_FLUSH || ph == PH_DRAIN) drain_n = drain_n - int'(dout_valid && drain_n > 0);
            else drain_n = 0;
            m_pc   = branch_target - (branch_target % LB);
            skip_w = int'((branch_target % LB) / 4);
            got    = 0;
            ph     = PH_FLUSH;
         end else if (ph == PH_RST) begin
            ph = PH_REQ;
         end else if (ph == PH_REQ) begin
            ph = credit ? PH_RECV : PH_STALL;
         end else if (ph == PH_STALL) begin
            if (credit) ph = PH_REQ;
         end else if (ph == PH_RECV) begin
            if (dout_valid) begin
               got = got + 1;
               if (got == WPL) begin
                  got = 0; skip_w = 0; m_pc = m_pc + LB; ph = PH_REQ;
               end
            end
         end else begin
            if (dout_valid && drain_n > 0) drain_n = drain_n - 1;
            ph = (drain_n > 0) ? PH_DRAIN : PH_REQ;
         end
      end
   end

   // One clock of stimulus; returns 4ns after the edge so outputs can be sampled.
   task automatic tick(input bit rst_n, input bit dv, input bit rd, input int cnt,
                       input bit br, input logic [31:0] tgt);
      @(posedge clk);
      #1;
      reset         = rst_n;
      dout_valid    = dv;
      rd_enable     = rd;
      fifo_count    = CW'(cnt);
      fifo_empty    = (cnt == 0);
      fifo_full     = (cnt >= DEPTH);
      branch_valid  = br;
      branch_target = tgt;
      #3;
   endtask

   int          req_cyc[$];
   logic [31:0] req_pc[$];
   int          exp_cyc[3] = '{1, 6, 11};
   logic [31:0] exp_pc[3]  = '{32'h0, 32'h10, 32'h20};
   int          pushes;
   int          nreq;

   initial begin
      reset = 1'b0; dout_valid = 1'b0; rd_enable = 1'b0; branch_valid = 1'b0;
      branch_target = '0; fifo_count = '0; fifo_empty = 1'b1; fifo_full = 1'b0;

      // Reset held with activity on the inputs: everything must stay quiet.
      repeat (3) tick(0, 1, 1, 3, 0, 32'h0);
      chk_b("rst_cache_req", cache_req, 1'b0);
      chk_b("rst_pop",       pop_fifo,  1'b0);
      chk_b("rst_push",      push_fifo, 1'b0);
      chk_b("rst_flush",     flush,     1'b0);
      chk_w("rst_pc",        pc_out,    RST_PC);
      chk_w("rst_word_idx",  32'(word_idx), 32'h0);

      // Steady fetch, one word per cycle into an empty FIFO with decode idle.
      pushes = 0;
      for (int k = 0; k < 16; k++) begin
         tick(1, 1, 0, 0, 0, 32'h0);
         if (cache_req) begin
            req_cyc.push_back(k);
            req_pc.push_back(pc_out);
         end
         if (push_fifo) pushes++;
      end
      chk_w("steady_req_count", 32'(req_cyc.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk_w("steady_req_cycle", (i < req_cyc.size()) ? 32'(req_cyc[i]) : 32'hFFFF_FFFF, 32'(exp_cyc[i]));
         chk_w("steady_req_pc",    (i < req_pc.size())  ? req_pc[i]       : 32'hFFFF_FFFF, exp_pc[i]);
      end
      chk_w("steady_pushes", 32'(pushes), 32'd12);

      // Credit stall: 13 of 16 entries used leaves no room for a line.
      nreq = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1, 0, 0, 13, 0, 32'h0);
         if (cache_req) nreq++;
      end
      chk_w("stall_no_req", 32'(nreq), 32'd0);
      tick(1, 0, 0, 12, 0, 32'h0);
      chk_b("stall_release_cycle", cache_req, 1'b0);
      tick(1, 0, 0, 12, 0, 32'h0);
      chk_b("stall_req_next", cache_req, 1'b1);
      chk_w("stall_req_pc", pc_out, 32'h30);

      // Bypass: decode reading with an empty FIFO takes the word directly.
      tick(1, 1, 1, 0, 0, 32'h0);
      chk_b("byp_bypass", bypass,    1'b1);
      chk_b("byp_push",   push_fifo, 1'b0);
      chk_b("byp_pop",    pop_fifo,  1'b0);
      repeat (3) tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 0, 0, 2, 0, 32'h0);                      // request line 0x40
      repeat (4) tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 0, 0, 2, 0, 32'h0);                      // request line 0x50
      chk_w("line50_pc", pc_out, 32'h50);

      // Redirect after one word of four: three stale words drain, then skip two.
      tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 0, 0, 2, 1, 32'h48);
      chk_b("br_push_blocked", push_fifo, 1'b0);
      tick(1, 1, 1, 2, 0, 32'h0);
      chk_b("br_flush_on",   flush,    1'b1);
      chk_b("br_flush_pop",  pop_fifo, 1'b0);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("br_flush_off",  flush,     1'b0);
      chk_b("br_drain_noreq", cache_req, 1'b0);
      tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 0, 0, 2, 0, 32'h0);
      chk_b("br_req",    cache_req, 1'b1);
      chk_w("br_req_pc", pc_out,    32'h40);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("br_skip0", push_fifo, 1'b0);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("br_skip1", push_fifo, 1'b0);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("br_word2_push", push_fifo, 1'b1);
      chk_w("br_word2_idx",  32'(word_idx), 32'd2);
      tick(1, 1, 0, 2, 0, 32'h0);

      // Redirect on the last word of a line: word dropped, no drain phase.
      tick(1, 0, 0, 2, 0, 32'h0);
      chk_w("last_line_pc", pc_out, 32'h50);
      repeat (3) tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 1, 0, 2, 1, 32'h104);
      chk_b("last_push_blocked", push_fifo, 1'b0);
      tick(1, 0, 0, 2, 0, 32'h0);
      chk_b("last_flush", flush, 1'b1);
      tick(1, 0, 0, 2, 0, 32'h0);
      chk_b("last_req_no_drain", cache_req, 1'b1);
      chk_w("last_req_pc", pc_out, 32'h100);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("last_skip0", push_fifo, 1'b0);
      tick(1, 1, 0, 2, 0, 32'h0);
      chk_b("last_word1_push", push_fifo, 1'b1);

      // Reset while draining.
      tick(1, 1, 0, 2, 0, 32'h0);
      tick(1, 0, 0, 2, 1, 32'h200);
      tick(1, 0, 0, 2, 0, 32'h0);
      tick(0, 1, 1, 2, 0, 32'h0);
      tick(1, 1, 1, 2, 0, 32'h0);
      chk_b("rdr_cache_req", cache_req, 1'b0);
      chk_b("rdr_pop",       pop_fifo,  1'b0);
      chk_b("rdr_push",      push_fifo, 1'b0);
      chk_b("rdr_flush",     flush,     1'b0);
      chk_w("rdr_pc",        pc_out,    RST_PC);
      chk_w("rdr_word_idx",  32'(word_idx), 32'h0);
      tick(1, 0, 0, 2, 0, 32'h0);
      chk_b("rdr_req_after", cache_req, 1'b1);

      // Random traffic against the model.
      for (int k = 0; k < 4000; k++) begin
         logic [31:0] t;
         int          cnt;
         t      = $urandom;
         t[1:0] = 2'b00;
         cnt    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, DEPTH - 1));
         tick(($urandom_range(0, 399) != 0),
              ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 1) == 1),
              cnt,
              ($urandom_range(0, 29) == 0),
              t);
      end
      tick(1, 0, 0, 0, 0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
